mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Two-port round-robin arbiter in front of the single-port data/program memory.
//   Accepts requests from the instruction-fetch port (IF, read-only) and the data port (DP, read/write).
//   Serialises them into one memory access at a time.
//   Drives the memory's we/addr/data inputs and returns the captured memory output to the granted requester.
// PARAMETERS
//   ADDR_WIDTH  6   memory word-address width
//   DATA_WIDTH  16  memory word width
// PORTS
//   clk       in   1           single clock, all state on rising edge
//   rst       in   1           asynchronous reset, active-high
//   if_req    in   1           IF read request; hold high with if_addr stable until if_valid
//   if_addr   in   ADDR_WIDTH  IF read address
//   if_valid  out  1           one-cycle pulse: if_rdata holds the result
//   if_rdata  out  DATA_WIDTH  IF read data (registered)
//   dp_req    in   1           DP request; hold high with dp_we/dp_addr/dp_wdata stable until dp_valid
//   dp_we     in   1           1 = write, 0 = read
//   dp_addr   in   ADDR_WIDTH  DP address
//   dp_wdata  in   DATA_WIDTH  DP write data
//   dp_valid  out  1           one-cycle pulse: DP access complete, dp_rdata valid
//   dp_rdata  out  DATA_WIDTH  DP read data (registered)
//   mem_we    out  1           memory write enable
//   mem_addr  out  ADDR_WIDTH  memory address
//   mem_data  out  DATA_WIDTH  memory write data
//   mem_out   in   DATA_WIDTH  memory combinational read data for mem_addr
//   busy      out  1           high in ACCESS and RESP states
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, last_grant=DP, all outputs 0, including mem_we.
//     A reset mid-access aborts it: no valid pulse, and no write after reset asserts.
//   FSM:
//     IDLE -> ACCESS when if_req|dp_req is sampled at a clock edge.
//       Winner latched into grant_sel. addr, we and wdata are latched into internal registers.
//     ACCESS (1 cycle): mem_addr/mem_data driven from the latched registers.
//       mem_we = latched we (always 0 for IF).
//       At the closing edge, mem_out is captured into the winner's rdata register.
//       The write, if any, commits at that same edge. Next state is RESP.
//     RESP (1 cycle): winner's valid=1. Requests are not sampled. Next state is IDLE, unconditionally.
//   Latency: req sampled at edge N -> valid high in cycle N+2. Max throughput is 1 access per 3 cycles.
//   Arbitration:
//     Only one requester high -> it wins.
//     Both high -> the port not equal to last_grant wins, and last_grant is updated to the winner.
//     The losing request stays pending and wins the next IDLE sample if it is still high.
//   Write rdata: dp_rdata on a write completion = the word at dp_addr before the write (pre-write value).
//   mem_we is high only in ACCESS state with latched we=1. It is never high in IDLE or RESP.
//   mem_addr/mem_data hold their last latched values outside ACCESS, so no glitching to the memory.
//   if_rdata/dp_rdata hold their values until overwritten by that port's next completion.
//   The other port's rdata and valid are untouched by a completion.
//   Requests dropped before being sampled are ignored. Changing operands after sampling has no effect.
//   Full address range 0..2**ADDR_WIDTH-1. No wrap or offset arithmetic is applied to addresses.
// TESTING
//   1. Reset: rst=1 with if_req=dp_req=1 -> all outputs 0, mem_we=0 for the whole reset. Release -> IF granted first.
//   2. DP write then read: dp_we=1, addr=5, wdata=16'hBEEF -> mem_we=1 for exactly one cycle.
//      Then dp_we=0, addr=5 -> dp_rdata=16'hBEEF, dp_valid pulses at cycle N+2.
//   3. Contention: if_req and dp_req held high continuously -> grants alternate IF,DP,IF,DP.
//      One valid every 3 cycles, never both valid together.
//   4. IF read: if_addr=3, memory word 3 = 16'h1234 -> if_rdata=16'h1234, if_valid 1 cycle.
//      dp_rdata is unchanged.
//   5. Pre-write value: word 7=16'h0001, DP write 16'h00FF to 7 -> dp_rdata=16'h0001. Next read of 7 returns 16'h00FF.
//   6. Reset mid-ACCESS of a DP write of 16'hAAAA to addr 9 -> no dp_valid; word 9 is not written after rst rises.
//      FSM returns to IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port memory.
// One access at a time: IDLE -> ACCESS (memory cycle) -> RESP (valid pulse) -> IDLE.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_valid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  dp_req,
    input  logic                  dp_we,
    input  logic [ADDR_WIDTH-1:0] dp_addr,
    input  logic [DATA_WIDTH-1:0] dp_wdata,
    output logic                  dp_valid,
    output logic [DATA_WIDTH-1:0] dp_rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_out,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {G_IF, G_DP} port_t;

    state_t                state_q, state_d;
    port_t                 grant_q, grant_d;
    port_t                 last_q, last_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] dp_rdata_q, dp_rdata_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= G_IF;
            last_q     <= G_DP;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            if_rdata_q <= '0;
            dp_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            if_rdata_q <= if_rdata_d;
            dp_rdata_q <= dp_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        if_rdata_d = if_rdata_q;
        dp_rdata_d = dp_rdata_q;
        case (state_q)
            IDLE: begin
                if (if_req || dp_req) begin
                    // The round-robin pointer only moves when both ports contend.
                    if (if_req && dp_req) begin
                        grant_d = (last_q == G_DP) ? G_IF : G_DP;
                        last_d  = grant_d;
                    end else begin
                        grant_d = if_req ? G_IF : G_DP;
                    end
                    if (grant_d == G_IF) begin
                        addr_d = if_addr;
                        we_d   = 1'b0;
                    end else begin
                        addr_d  = dp_addr;
                        we_d    = dp_we;
                        wdata_d = dp_wdata;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Captured at the same edge the write commits, so writes return the old word.
                if (grant_q == G_IF) if_rdata_d = mem_out;
                else                 dp_rdata_d = mem_out;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_we   = (state_q == ACCESS) && we_q;
    assign mem_addr = addr_q;
    assign mem_data = wdata_q;
    assign if_valid = (state_q == RESP) && (grant_q == G_IF);
    assign dp_valid = (state_q == RESP) && (grant_q == G_DP);
    assign if_rdata = if_rdata_q;
    assign dp_rdata = dp_rdata_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level model predicts grant order,
// completion times and read data; a behavioural memory sits on the memory port.
module tb_mem_arbiter;

    localparam int AW = 6;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, dp_req, dp_we;
    logic [AW-1:0] if_addr, dp_addr;
    logic [DW-1:0] dp_wdata;
    logic          if_valid, dp_valid, mem_we, busy;
    logic [DW-1:0] if_rdata, dp_rdata, mem_data, mem_out;
    logic [AW-1:0] mem_addr;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
        .dp_req(dp_req), .dp_we(dp_we), .dp_addr(dp_addr), .dp_wdata(dp_wdata),
        .dp_valid(dp_valid), .dp_rdata(dp_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_out(mem_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural single-port memory: combinational read, write at the clock edge.
    logic [DW-1:0] mem [2**AW];
    assign mem_out = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_data;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } op_t;

    op_t q_if[$], q_dp[$];
    op_t cur [2];
    bit  active [2];
    bit  gap_en;

    // Reference model state
    logic [DW-1:0] ref_mem [2**AW];
    int            k;
    bit            has_acc;
    int            a;
    int            acc_port;
    op_t           acc_op;
    logic [DW-1:0] exp_rd, e_if_rd, e_dp_rd;
    int            lg;           // port granted last under contention (0 IF, 1 DP)

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h k=%0d t=%0t", tag, got, exp, k, $time);
        end
    endtask

    task automatic model_reset();
        has_acc = 0; a = 0; k = 0; lg = 1;
        e_if_rd = '0; e_dp_rd = '0;
        active[0] = 0; active[1] = 0;
        q_if.delete(); q_dp.delete();
        if_req = 0; dp_req = 0;
    endtask

    // One cycle, entered and left at a falling edge: check, drive, predict, advance.
    task automatic step();
        bit in_access, in_resp;
        int w;
        in_access = has_acc && (k == a);
        in_resp   = has_acc && (k == a + 1);
        if (in_resp) begin
            if (acc_port == 0) e_if_rd = exp_rd;
            else               e_dp_rd = exp_rd;
            active[acc_port] = 0;
        end
        chk("busy",     {31'd0, busy},     {31'd0, in_access | in_resp});
        chk("mem_we",   {31'd0, mem_we},   {31'd0, in_access & acc_op.we});
        chk("if_valid", {31'd0, if_valid}, {31'd0, in_resp && acc_port == 0});
        chk("dp_valid", {31'd0, dp_valid}, {31'd0, in_resp && acc_port == 1});
        chk("if_rdata", {16'd0, if_rdata}, {16'd0, e_if_rd});
        chk("dp_rdata", {16'd0, dp_rdata}, {16'd0, e_dp_rd});
        if (in_access) begin
            chk("mem_addr", {26'd0, mem_addr}, {26'd0, acc_op.addr});
            if (acc_op.we) chk("mem_data", {16'd0, mem_data}, {16'd0, acc_op.wd});
        end

        if (!active[0] && q_if.size() > 0 && (!gap_en || $urandom_range(1, 0) == 1)) begin
            cur[0] = q_if.pop_front(); active[0] = 1;
        end
        if (!active[1] && q_dp.size() > 0 && (!gap_en || $urandom_range(1, 0) == 1)) begin
            cur[1] = q_dp.pop_front(); active[1] = 1;
        end
        if_req   = active[0];
        if_addr  = active[0] ? cur[0].addr : AW'($urandom);
        dp_req   = active[1];
        dp_we    = active[1] ? cur[1].we   : 1'($urandom);
        dp_addr  = active[1] ? cur[1].addr : AW'($urandom);
        dp_wdata = active[1] ? cur[1].wd   : DW'($urandom);

        // A new request can be taken three edges after the previous one.
        if ((!has_acc || k + 1 >= a + 3) && (active[0] || active[1])) begin
            if (active[0] && active[1]) begin
                w  = 1 - lg;
                lg = w;
            end else begin
                w = active[0] ? 0 : 1;
            end
            has_acc  = 1;
            a        = k + 1;
            acc_port = w;
            acc_op   = cur[w];
            if (w == 0) acc_op.we = 1'b0;
            exp_rd = ref_mem[acc_op.addr];
            if (acc_op.we) ref_mem[acc_op.addr] = acc_op.wd;
        end
        @(posedge clk);
        k++;
        @(negedge clk);
    endtask

    task automatic run_until_idle(input int max_cycles);
        int n = 0;
        while ((q_if.size() > 0 || q_dp.size() > 0 || active[0] || active[1] ||
                (has_acc && k <= a + 1)) && n < max_cycles) begin
            step();
            n++;
        end
        chk("drain_timeout", {31'd0, n >= max_cycles}, 32'd0);
    endtask

    function automatic op_t mk(input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        op_t o;
        o.we = we; o.addr = ad; o.wd = wd;
        return o;
    endfunction

    initial begin
        logic [DW-1:0] old9;
        int            n;
        for (int i = 0; i < 2**AW; i++) begin
            ref_mem[i] = DW'($urandom);
            mem[i]     = ref_mem[i];
        end
        ref_mem[3] = 16'h1234; mem[3] = 16'h1234;

        // Reset with both requests high: everything stays 0.
        rst = 1; if_req = 1; dp_req = 1; dp_we = 1;
        if_addr = 3; dp_addr = 5; dp_wdata = 16'hBEEF;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
            chk("rst_busy",   {31'd0, busy},   32'd0);
            chk("rst_valid",  {30'd0, if_valid, dp_valid}, 32'd0);
            chk("rst_rdata",  {if_rdata, dp_rdata}, 32'd0);
            chk("rst_mem",    {10'd0, mem_addr, mem_data}, 32'd0);
        end
        model_reset();
        gap_en = 0;
        // IF read of 3 and DP write BEEF to 5 contend right out of reset; IF must win.
        cur[0] = mk(0, 3, 0);           active[0] = 1; if_req = 1;
        cur[1] = mk(1, 5, 16'hBEEF);    active[1] = 1; dp_req = 1;
        rst = 0;
        q_dp.push_back(mk(0, 5, 0));
        q_if.push_back(mk(0, 3, 0));
        run_until_idle(100);
        chk("rd5_beef",  {16'd0, dp_rdata}, 32'h0000BEEF);
        chk("if_1234",   {16'd0, if_rdata}, 32'h00001234);

        // Pre-write value is returned on a write.
        q_dp.push_back(mk(1, 7, 16'h0001));
        q_dp.push_back(mk(1, 7, 16'h00FF));
        run_until_idle(100);
        chk("prewrite7", {16'd0, dp_rdata}, 32'h00000001);
        q_dp.push_back(mk(0, 7, 0));
        run_until_idle(100);
        chk("read7_ff",  {16'd0, dp_rdata}, 32'h000000FF);

        // Continuous contention.
        for (int i = 0; i < 8; i++) begin
            q_if.push_back(mk(0, AW'($urandom), 0));
            q_dp.push_back(mk(1'($urandom), AW'($urandom), DW'($urandom)));
        end
        run_until_idle(200);

        // Random traffic with gaps, then back-to-back, including boundary addresses.
        gap_en = 1;
        q_dp.push_back(mk(1, 0, 16'hA5A5));
        q_dp.push_back(mk(1, AW'(2**AW - 1), 16'h5A5A));
        q_if.push_back(mk(0, AW'(2**AW - 1), 0));
        q_if.push_back(mk(0, 0, 0));
        for (int i = 0; i < 150; i++) begin
            q_if.push_back(mk(0, AW'($urandom), 0));
            q_dp.push_back(mk(1'($urandom), AW'($urandom), DW'($urandom)));
        end
        run_until_idle(4000);
        gap_en = 0;
        for (int i = 0; i < 60; i++) begin
            q_if.push_back(mk(0, AW'($urandom), 0));
            q_dp.push_back(mk(1'($urandom), AW'($urandom), DW'($urandom)));
        end
        run_until_idle(1000);
        for (int i = 0; i < 2**AW; i++) chk("mem_final", {16'd0, mem[i]}, {16'd0, ref_mem[i]});

        // Reset during the ACCESS cycle of a DP write of AAAA to 9.
        old9 = ref_mem[9];
        q_dp.push_back(mk(1, 9, 16'hAAAA));
        n = 0;
        while (!(has_acc && k == a && acc_port == 1) && n < 20) begin
            step();
            n++;
        end
        chk("abort_timeout", {31'd0, n >= 20}, 32'd0);
        rst = 1;
        #1;
        chk("abort_mem_we", {31'd0, mem_we},   32'd0);
        chk("abort_busy",   {31'd0, busy},     32'd0);
        chk("abort_dpv",    {31'd0, dp_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_dpv_hold", {30'd0, dp_valid, mem_we}, 32'd0);
        end
        chk("abort_word9", {16'd0, mem[9]}, {16'd0, old9});
        model_reset();
        ref_mem[9] = old9;
        rst = 0;
        @(negedge clk);
        chk("abort_idle", {31'd0, busy}, 32'd0);
        q_dp.push_back(mk(0, 9, 0));
        run_until_idle(100);
        chk("read9_old", {16'd0, dp_rdata}, {16'd0, old9});

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
